// File: rtl/dec4_scan_pkg.sv
// Shared constants, state encoding and pointer helper for the 4-to-16 decoder scan sequencer.
package dec4_scan_pkg;

    localparam int CH_N   = 16;
    localparam int SEL_W  = 4;
    localparam int MISS_W = SEL_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEEK  = 2'd1,
        DWELL = 2'd2,
        DONE  = 2'd3
    } scan_state_t;

    // Pointer advance; wraps naturally at the 4-bit boundary in both directions.
    function automatic logic [SEL_W-1:0] ptr_step(input logic [SEL_W-1:0] p, input logic down);
        return down ? p - 1'b1 : p + 1'b1;
    endfunction

endpackage

// File: rtl/dec4_dwell_ctr.sv
// Loadable down-counter timing how long the current channel is held; zero flags terminal count.
module dec4_dwell_ctr #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               dec,
    input  logic [DWELL_W-1:0] load_val,
    output logic               zero
);

    logic [DWELL_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/dec4_scan_sequencer.sv
// Channel-select sequencer feeding the 4-to-16 decoder: skips masked channels, dwells on enabled ones.
// Optional SCAN_REVERSE_EN adds a latched dir input for downward scanning.
//
// state | meaning
// IDLE  | waiting for start, busy low
// SEEK  | test mask[ptr], one channel per cycle
// DWELL | holding sel on an enabled channel until the dwell counter hits zero
// DONE  | one-cycle done pulse, then back to IDLE
module dec4_scan_sequencer
    import dec4_scan_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               cont,
    input  logic [DWELL_W-1:0] dwell,
`ifdef SCAN_REVERSE_EN
    input  logic               dir,
`endif
    input  logic [CH_N-1:0]    mask,
    output logic [SEL_W-1:0]   sel,
    output logic               sel_valid,
    output logic               step,
    output logic               busy,
    output logic               done
);

    scan_state_t        state;
    logic [SEL_W-1:0]   ptr;
    logic [MISS_W-1:0]  miss;
    logic [MISS_W-1:0]  miss_inc;
    logic               cont_l;
    logic [DWELL_W-1:0] dwell_l;
    logic               down_l;
    logic               down_start;
    logic [SEL_W-1:0]   ptr_first;
    logic [SEL_W-1:0]   ptr_last;
    logic [SEL_W-1:0]   ptr_next;
    logic               at_end;
    logic               lap_empty;
    logic               ctr_load;
    logic               ctr_dec;
    logic               ctr_zero;

`ifdef SCAN_REVERSE_EN
    assign down_start = dir;
`else
    assign down_start = 1'b0;
`endif

    assign ptr_first = down_start ? SEL_W'(CH_N - 1) : '0;
    assign ptr_last  = down_l ? '0 : SEL_W'(CH_N - 1);
    assign ptr_next  = ptr_step(ptr, down_l);
    assign at_end    = (ptr == ptr_last) && !cont_l;
    assign miss_inc  = miss + 1'b1;
    assign lap_empty = (miss_inc == MISS_W'(CH_N));

    assign ctr_load = (state == SEEK) && mask[ptr] && !stop;
    assign ctr_dec  = (state == DWELL);

    dec4_dwell_ctr #(
        .DWELL_W (DWELL_W)
    ) u_dwell_ctr (
        .clk      (clk),
        .rst      (rst),
        .load     (ctr_load),
        .dec      (ctr_dec),
        .load_val (dwell_l - 1'b1),
        .zero     (ctr_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            miss      <= '0;
            cont_l    <= 1'b0;
            dwell_l   <= DWELL_W'(1);
            down_l    <= 1'b0;
            sel       <= '0;
            sel_valid <= 1'b0;
            step      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            step <= 1'b0;
            done <= 1'b0;
            if (stop && (state != IDLE)) begin
                state     <= IDLE;
                sel_valid <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !stop) begin
                            cont_l  <= cont;
                            dwell_l <= (dwell == '0) ? DWELL_W'(1) : dwell;
                            down_l  <= down_start;
                            ptr     <= ptr_first;
                            miss    <= '0;
                            busy    <= 1'b1;
                            state   <= SEEK;
                        end
                    end
                    SEEK: begin
                        if (mask[ptr]) begin
                            sel       <= ptr;
                            sel_valid <= 1'b1;
                            step      <= 1'b1;
                            state     <= DWELL;
                        end else begin
                            miss <= miss_inc;
                            if (at_end || lap_empty) begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= DONE;
                            end else begin
                                ptr <= ptr_next;
                            end
                        end
                    end
                    DWELL: begin
                        // Mask is not consulted here, so a mid-dwell mask change never truncates the hold.
                        if (ctr_zero) begin
                            sel_valid <= 1'b0;
                            miss      <= '0;
                            if (at_end) begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= DONE;
                            end else begin
                                ptr   <= ptr_next;
                                state <= SEEK;
                            end
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dec4_scan_sequencer.sv
// Bench for dec4_scan_sequencer: timeline model of each scan compared every cycle, plus literal pins.
module tb_dec4_scan_sequencer;

    localparam int DWELL_W = 8;
    localparam int MAXT    = 1024;

    logic               clk;
    logic               rst;
    logic               start;
    logic               stop;
    logic               cont;
    logic [DWELL_W-1:0] dwell;
    logic [15:0]        mask;
`ifdef SCAN_REVERSE_EN
    logic               dir;
`endif
    logic [3:0]         sel;
    logic               sel_valid;
    logic               step;
    logic               busy;
    logic               done;

    dec4_scan_sequencer #(
        .DWELL_W (DWELL_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .cont      (cont),
        .dwell     (dwell),
`ifdef SCAN_REVERSE_EN
        .dir       (dir),
`endif
        .mask      (mask),
        .sel       (sel),
        .sel_valid (sel_valid),
        .step      (step),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    int e_sel   [MAXT];
    bit e_valid [MAXT];
    bit e_step  [MAXT];
    bit e_busy  [MAXT];
    bit e_done  [MAXT];
    int mdl_done_t;
    int mdl_len;
    bit mdl_on = 1'b0;
    int t0;
    int last_sel = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Timeline model: t counts cycles after the edge that samples start.
    task automatic build_model(input logic [15:0] m, input bit c, input int d, input bit rev, input int limit);
        int t, pos, ch, misses, dl, cur;
        bit fin;
        for (int i = 0; i < MAXT; i++) begin
            e_sel[i] = -1; e_valid[i] = 0; e_step[i] = 0; e_busy[i] = 0; e_done[i] = 0;
        end
        dl = (d == 0) ? 1 : d;
        mdl_done_t = -1;
        t = 1; pos = 0; misses = 0; fin = 0;
        while (!fin && t < limit) begin
            ch = rev ? 15 - pos : pos;
            e_busy[t] = 1;
            if (m[ch]) begin
                for (int k = 1; k <= dl; k++) begin
                    if (t + k < MAXT) begin
                        e_valid[t + k] = 1; e_busy[t + k] = 1; e_sel[t + k] = ch;
                    end
                end
                if (t + 1 < MAXT) e_step[t + 1] = 1;
                misses = 0;
                t = t + dl + 1;
            end else begin
                misses++;
                t = t + 1;
            end
            if ((pos == 15 && !c) || misses == 16) fin = 1;
            pos = (pos + 1) % 16;
        end
        if (fin) begin
            mdl_done_t = t;
            if (t < MAXT) e_done[t] = 1;
        end
        cur = last_sel;
        for (int i = 0; i < MAXT; i++) begin
            if (e_sel[i] >= 0) cur = e_sel[i];
            else e_sel[i] = cur;
        end
    endtask

    always @(negedge clk) begin
        int t;
        if (mdl_on) begin
            t = cyc - t0;
            if (t >= 1 && t < mdl_len) begin
                chk($sformatf("sel@%0d", t), 32'(sel), 32'(e_sel[t]));
                chk($sformatf("sel_valid@%0d", t), 32'(sel_valid), 32'(e_valid[t]));
                chk($sformatf("step@%0d", t), 32'(step), 32'(e_step[t]));
                chk($sformatf("busy@%0d", t), 32'(busy), 32'(e_busy[t]));
                chk($sformatf("done@%0d", t), 32'(done), 32'(e_done[t]));
            end
        end
    end

    // Returns just after the edge whose result the model covers last (observed at t=len-1).
    task automatic run_scan(input logic [15:0] m, input bit c, input int d, input bit rev, input int len);
        build_model(m, c, d, rev, (len > 0) ? len : 600);
        mdl_len = (len > 0) ? len : mdl_done_t + 3;
        @(posedge clk); #1;
        mask  = m;
        cont  = c;
        dwell = DWELL_W'(d);
`ifdef SCAN_REVERSE_EN
        dir   = rev;
`endif
        start  = 1'b1;
        t0     = cyc;
        mdl_on = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (mdl_len - 2) @(posedge clk);
        #1;
    endtask

    task automatic finish_run();
        @(negedge clk); #1;
        mdl_on   = 1'b0;
        last_sel = e_sel[mdl_len - 1];
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_sel"}, 32'(sel), 32'(0));
        chk({tag, "_sel_valid"}, 32'(sel_valid), 32'(0));
        chk({tag, "_step"}, 32'(step), 32'(0));
        chk({tag, "_busy"}, 32'(busy), 32'(0));
        chk({tag, "_done"}, 32'(done), 32'(0));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; cont = 1'b0; dwell = '0; mask = '0;
`ifdef SCAN_REVERSE_EN
        dir = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Full mask, dwell 2, single pass.
        run_scan(16'hFFFF, 1'b0, 2, 1'b0, 0);
        finish_run();
        chk("pin_full_done_t", 32'(mdl_done_t), 32'(49));
        chk("pin_full_sel47", 32'(e_sel[47]), 32'(15));
        chk("pin_full_gap4", 32'(e_valid[4]), 32'(0));

        // Endpoints only: 14 skipped channels between them.
        run_scan(16'h8001, 1'b0, 1, 1'b0, 0);
        finish_run();
        chk("pin_ends_done_t", 32'(mdl_done_t), 32'(19));
        chk("pin_ends_sel18", 32'(e_sel[18]), 32'(15));
        chk("pin_ends_valid17", 32'(e_valid[17]), 32'(0));

        // Continuous on channel 4, period 19, stopped mid-dwell.
        run_scan(16'h0010, 1'b1, 3, 1'b0, 65);
        stop = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("stop_busy", 32'(busy), 32'(0));
        chk("stop_sel_valid", 32'(sel_valid), 32'(0));
        chk("stop_done", 32'(done), 32'(0));
        @(posedge clk); #1;
        stop = 1'b0;
        mdl_on = 1'b0;
        last_sel = e_sel[mdl_len - 1];
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stop_no_done", 32'(done), 32'(0));
        end
        chk("pin_cont_valid63", 32'(e_valid[63]), 32'(1));
        chk("pin_cont_sel63", 32'(e_sel[63]), 32'(4));
        chk("pin_cont_valid62", 32'(e_valid[62]), 32'(0));
        chk("pin_cont_step25", 32'(e_step[25]), 32'(1));

        // Empty mask: 16 SEEK cycles then done.
        run_scan(16'h0000, 1'b0, 4, 1'b0, 0);
        finish_run();
        chk("pin_empty_done_t", 32'(mdl_done_t), 32'(17));
        chk("pin_empty_busy16", 32'(e_busy[16]), 32'(1));

        // Dwell 0 behaves as 1.
        run_scan(16'h0005, 1'b0, 0, 1'b0, 0);
        finish_run();
        chk("pin_d0_done_t", 32'(mdl_done_t), 32'(19));
        chk("pin_d0_valid5", 32'(e_valid[5]), 32'(1));
        chk("pin_d0_valid6", 32'(e_valid[6]), 32'(0));

        // Reset asserted during the first dwell.
        run_scan(16'hFFFF, 1'b0, 5, 1'b0, 5);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk_idle_outputs("rst_mid");
        @(posedge clk); #1;
        rst = 1'b0;
        mdl_on = 1'b0;
        last_sel = 0;
        repeat (2) @(posedge clk);

`ifdef SCAN_REVERSE_EN
        run_scan(16'h00FF, 1'b0, 1, 1'b1, 0);
        finish_run();
        chk("pin_rev_done_t", 32'(mdl_done_t), 32'(25));
        chk("pin_rev_sel10", 32'(e_sel[10]), 32'(7));
        chk("pin_rev_sel24", 32'(e_sel[24]), 32'(0));
`endif

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
